spatz_cache_bank_adapter: RTL and testbench
===========================================

Name: spatz_cache_bank_adapter

Overview:
- Per-bank front-end on the cache side of the hybrid cache/SPM SRAM wrapper; one instance per bank, driving that bank's cache request port.
- Converts a valid/ready cache request stream into the wrapper's stallable req/ready bank port.
- Tracks fixed-latency read returns and captures bank read data into a response FIFO with valid/ready, tag and error flag.
- Filters accesses that fall into the SPM region so they never reach the bank.

Parameters:
- DataWidth, 32, data word width.
- BeWidth, 4, byte-enable width (DataWidth/8).
- BankAddrWidth, 10, bank-local word address width.
- IdWidth, 4, request tag width, returned with the response.
- MemoryResponseLatency, 1, bank read latency in cycles (≥1); must match the wrapper.
- RespDepth, 4, response FIFO depth (≥2); also the read-credit limit.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- spm_size_i  in  BankAddrWidth  addresses below this value belong to SPM.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  BankAddrWidth  bank-local word address.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  BeWidth  byte enables.
- req_id_i  in  IdWidth  request tag.
- bank_req_o  out  1  request to wrapper cache port.
- bank_we_o  out  1  write enable.
- bank_addr_o  out  BankAddrWidth  address.
- bank_wdata_o  out  DataWidth  write data.
- bank_be_o  out  BeWidth  byte enables.
- bank_ready_i  in  1  wrapper grant; low when SPM owns the bank this cycle.
- bank_rdata_i  in  DataWidth  read data, valid MemoryResponseLatency cycles after the grant.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  read response ready.
- rsp_data_o  out  DataWidth  read data.
- rsp_id_o  out  IdWidth  tag of the originating read.
- rsp_err_o  out  1  read targeted the SPM region; data is 0.
- illegal_wr_o  out  1  one-cycle pulse when an SPM-region write is dropped.

Behaviour:
- Reset (rst_i high at a clock edge): clears the request queue, the latency pipeline, the response FIFO and the credit counter. Outputs in the cycle after reset: req_ready_o=1, bank_req_o=0, rsp_valid_o=0, rsp_err_o=0, illegal_wr_o=0, data/id outputs 0.
- Reset mid-operation discards in-flight reads; bank data returning after reset is ignored.
- Request queue:
  - 2-entry FIFO; accept when req_valid_i && req_ready_o.
  - req_ready_o = (queue count < 2). It is purely registered; there is no combinational path from bank_ready_i.
  - Sustains 1 request/cycle.
- Head classification:
  - illegal = (head.addr < spm_size_i), evaluated at issue time.
  - Legal write: bank_req_o=1; pops on bank_req_o && bank_ready_i; no response.
  - Legal read: bank_req_o=1 only if credits are available; pops on grant.
  - Illegal write: bank_req_o=0; pops immediately; illegal_wr_o=1 that cycle.
  - Illegal read: bank_req_o=0; needs a credit; pops and enters the latency pipeline with err=1.
  - When bank_ready_i=0, the head holds and bank_* outputs stay stable until granted.
- Credits:
  - outstanding = reads in the latency pipeline + response FIFO occupancy.
  - A read (legal or illegal) issues only if outstanding < RespDepth, with outstanding taken from registered counts.
  - A pop in the same cycle frees its credit only from the next cycle.
- Latency pipeline: shift register of depth MemoryResponseLatency carrying {valid, id, err}. Issue in cycle c → entry exits in cycle c+L, where bank_rdata_i is captured (0 if err) and pushed into the response FIFO.
- Response FIFO:
  - rsp_valid_o is asserted from cycle c+L+1.
  - Pop on rsp_valid_o && rsp_ready_i.
  - Strict in-order return.
  - It never overflows (credit-guaranteed); simultaneous push and pop when full is legal.
- Minimum read latency, from input acceptance in cycle t: rsp_valid_o in cycle t+L+2.
- Writes and reads are issued in order; a read after a write to the same address observes the write.
- Stalled heads do not block responses already in flight.

Test Plan:
1. L=1, spm_size_i=0, bank_ready_i=1: read addr 5 id 3 accepted in cycle 0 → bank_req_o in cycle 1; bank returns 0xCAFE in cycle 2 → rsp_valid_o in cycle 3 with data 0xCAFE, id 3, err 0.
2. Back-to-back: write 0x1234 to addr 7, then read addr 7 in consecutive cycles → both granted in consecutive cycles; one response with data 0x1234; req_ready_o stays 1 throughout.
3. bank_ready_i=0 for 3 cycles with a read at head → bank_req_o/addr held stable, no pop; queue fills and req_ready_o=0 after 2 accepts; issue resumes on the first ready cycle and ids return in order.
4. spm_size_i=16: read addr 4 id 9 → no bank_req_o, response with err=1, data 0, id 9. Write addr 4 → illegal_wr_o pulses once, no bank_req_o. Read addr 16 → legal.
5. RespDepth=4, rsp_ready_i=0, 6 reads → exactly 4 issued to the bank; 5th held at head until rsp_ready_i pops one, then issues the cycle after the pop; no data lost.
6. rst_i asserted while 2 reads are in flight → after reset no rsp_valid_o from stale returns, req_ready_o=1, credits fully restored (4 new reads issue without stall).

Source files
------------

// File: rtl/spatz_cache_bank_adapter.sv
// Cache-side bank front-end of the hybrid cache/SPM SRAM wrapper.
// Queues requests, filters SPM-region hits, returns reads in order.
module spatz_cache_bank_adapter #(
    parameter int DataWidth             = 32,
    parameter int BeWidth               = 4,
    parameter int BankAddrWidth         = 10,
    parameter int IdWidth               = 4,
    parameter int MemoryResponseLatency = 1,
    parameter int RespDepth             = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BankAddrWidth-1:0] spm_size_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [BankAddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0]     req_wdata_i,
    input  logic [BeWidth-1:0]       req_be_i,
    input  logic [IdWidth-1:0]       req_id_i,
    output logic                     bank_req_o,
    output logic                     bank_we_o,
    output logic [BankAddrWidth-1:0] bank_addr_o,
    output logic [DataWidth-1:0]     bank_wdata_o,
    output logic [BeWidth-1:0]       bank_be_o,
    input  logic                     bank_ready_i,
    input  logic [DataWidth-1:0]     bank_rdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DataWidth-1:0]     rsp_data_o,
    output logic [IdWidth-1:0]       rsp_id_o,
    output logic                     rsp_err_o,
    output logic                     illegal_wr_o
);
    localparam int Lat  = MemoryResponseLatency;
    localparam int PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int CntW = $clog2(RespDepth + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(RespDepth);

    logic                     q_we    [2];
    logic [BankAddrWidth-1:0] q_addr  [2];
    logic [DataWidth-1:0]     q_wdata [2];
    logic [BeWidth-1:0]       q_be    [2];
    logic [IdWidth-1:0]       q_id    [2];
    logic [1:0]               q_cnt;
    logic                     q_wp, q_rp;
    logic                     q_push, q_pop;

    logic head_v, head_ill, credit_ok, iss_rd;

    logic               pipe_v   [Lat];
    logic [IdWidth-1:0] pipe_id  [Lat];
    logic               pipe_err [Lat];

    logic [DataWidth-1:0] f_data [RespDepth];
    logic [IdWidth-1:0]   f_id   [RespDepth];
    logic                 f_err  [RespDepth];
    logic [PtrW-1:0]      f_wp, f_rp;
    logic [CntW-1:0]      f_cnt, credit_cnt;
    logic                 f_push, f_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign req_ready_o = (q_cnt != 2'd2);
    assign q_push      = req_valid_i && req_ready_o;
    assign head_v      = (q_cnt != 2'd0);
    assign head_ill    = (q_addr[q_rp] < spm_size_i);
    assign credit_ok   = (credit_cnt < CntMax);

    assign bank_we_o    = head_v && q_we[q_rp];
    assign bank_addr_o  = head_v ? q_addr[q_rp]  : '0;
    assign bank_wdata_o = head_v ? q_wdata[q_rp] : '0;
    assign bank_be_o    = head_v ? q_be[q_rp]    : '0;

    // Head issue decision: bank request, queue pop, read credit use.
    always_comb begin
        bank_req_o   = 1'b0;
        q_pop        = 1'b0;
        iss_rd       = 1'b0;
        illegal_wr_o = 1'b0;
        if (head_v) begin
            if (head_ill && q_we[q_rp]) begin
                q_pop        = 1'b1;
                illegal_wr_o = 1'b1;
            end else if (head_ill) begin
                q_pop  = credit_ok;
                iss_rd = credit_ok;
            end else if (q_we[q_rp]) begin
                bank_req_o = 1'b1;
                q_pop      = bank_ready_i;
            end else begin
                bank_req_o = credit_ok;
                q_pop      = credit_ok && bank_ready_i;
                iss_rd     = credit_ok && bank_ready_i;
            end
        end
    end

    // Request queue pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_cnt <= 2'd0;
            q_wp  <= 1'b0;
            q_rp  <= 1'b0;
        end else begin
            if (q_push) q_wp <= ~q_wp;
            if (q_pop)  q_rp <= ~q_rp;
            q_cnt <= q_cnt + {1'b0, q_push} - {1'b0, q_pop};
        end
    end

    // Request queue storage, written on accept.
    always_ff @(posedge clk_i) begin
        if (q_push) begin
            q_we[q_wp]    <= req_we_i;
            q_addr[q_wp]  <= req_addr_i;
            q_wdata[q_wp] <= req_wdata_i;
            q_be[q_wp]    <= req_be_i;
            q_id[q_wp]    <= req_id_i;
        end
    end

    // Read latency pipeline valid bits; cleared so stale returns are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Lat; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= iss_rd;
            for (int i = 1; i < Lat; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    // Read latency pipeline tag and error payload.
    always_ff @(posedge clk_i) begin
        pipe_id[0]  <= q_id[q_rp];
        pipe_err[0] <= head_ill;
        for (int i = 1; i < Lat; i++) begin
            pipe_id[i]  <= pipe_id[i-1];
            pipe_err[i] <= pipe_err[i-1];
        end
    end

    assign f_push      = pipe_v[Lat-1];
    assign rsp_valid_o = (f_cnt != '0);
    assign f_pop       = rsp_valid_o && rsp_ready_i;
    assign rsp_data_o  = rsp_valid_o ? f_data[f_rp] : '0;
    assign rsp_id_o    = rsp_valid_o ? f_id[f_rp]   : '0;
    assign rsp_err_o   = rsp_valid_o && f_err[f_rp];

    // Response FIFO pointers, occupancy and outstanding-read credits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_wp       <= '0;
            f_rp       <= '0;
            f_cnt      <= '0;
            credit_cnt <= '0;
        end else begin
            if (f_push) f_wp <= ptr_inc(f_wp);
            if (f_pop)  f_rp <= ptr_inc(f_rp);
            f_cnt      <= f_cnt + CntW'(f_push) - CntW'(f_pop);
            credit_cnt <= credit_cnt + CntW'(iss_rd) - CntW'(f_pop);
        end
    end

    // Response FIFO storage; SPM-region reads return zero data.
    always_ff @(posedge clk_i) begin
        if (f_push) begin
            f_data[f_wp] <= pipe_err[Lat-1] ? '0 : bank_rdata_i;
            f_id[f_wp]   <= pipe_id[Lat-1];
            f_err[f_wp]  <= pipe_err[Lat-1];
        end
    end

endmodule

// File: tb/tb_spatz_cache_bank_adapter.sv
// Bench for spatz_cache_bank_adapter: directed scenarios plus a
// randomized run checked against an in-order request-level model.
module tb_spatz_cache_bank_adapter;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int AW = 10;
    localparam int IW = 4;
    localparam int L  = 1;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] spm_size_i;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_be_i;
    logic [IW-1:0] req_id_i;
    logic          bank_req_o, bank_we_o;
    logic [AW-1:0] bank_addr_o;
    logic [DW-1:0] bank_wdata_o;
    logic [BW-1:0] bank_be_o;
    logic          bank_ready_i;
    logic [DW-1:0] bank_rdata_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [DW-1:0] rsp_data_o;
    logic [IW-1:0] rsp_id_o;
    logic          rsp_err_o, illegal_wr_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spatz_cache_bank_adapter #(
        .DataWidth(DW), .BeWidth(BW), .BankAddrWidth(AW), .IdWidth(IW),
        .MemoryResponseLatency(L), .RespDepth(RD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .spm_size_i(spm_size_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_id_i(req_id_i),
        .bank_req_o(bank_req_o), .bank_we_o(bank_we_o),
        .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
        .bank_be_o(bank_be_o), .bank_ready_i(bank_ready_i),
        .bank_rdata_i(bank_rdata_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
        .illegal_wr_o(illegal_wr_o)
    );

    // Behavioural SRAM bank: writes on grant, read data L cycles later.
    logic          bk_v [L];
    logic [DW-1:0] bk_d [L];
    logic [DW-1:0] bk_junk;
    logic [DW-1:0] bmem [1024];
    bit            bk_init;
    assign bank_rdata_i = bk_v[L-1] ? bk_d[L-1] : bk_junk;
    always @(posedge clk) begin
        if (!bk_init) begin
            for (int i = 0; i < 1024; i++) bmem[i] = '0;
            bk_init = 1'b1;
        end
        bk_junk <= $urandom | 32'h1;
        bk_v[0] <= bank_req_o && bank_ready_i && !bank_we_o;
        bk_d[0] <= bmem[bank_addr_o];
        for (int i = 1; i < L; i++) begin
            bk_v[i] <= bk_v[i-1];
            bk_d[i] <= bk_d[i-1];
        end
        if (bank_req_o && bank_ready_i && bank_we_o)
            for (int b = 0; b < BW; b++)
                if (bank_be_o[b]) bmem[bank_addr_o][b*8+:8] = bank_wdata_o[b*8+:8];
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          e;
    } rsp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle_in();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        req_id_i    = '0;
    endtask

    task automatic drv(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [IW-1:0] id);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = '1;
        req_id_i    = id;
    endtask

    task automatic test_reset();
        idle_in();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        mid();
        checks++;
        if ({req_ready_o, bank_req_o, rsp_valid_o, rsp_err_o, illegal_wr_o} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got %b exp 10000",
                     {req_ready_o, bank_req_o, rsp_valid_o, rsp_err_o, illegal_wr_o});
        end
        checks++;
        if ({rsp_data_o, rsp_id_o, bank_addr_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got %h/%h/%h exp 0", rsp_data_o, rsp_id_o, bank_addr_o);
        end
        tick();
    endtask

    task automatic test_single_read();
        drv(1'b1, 10'd5, 32'hCAFE, 4'd0);
        tick();
        idle_in();
        repeat (3) tick();
        drv(1'b0, 10'd5, '0, 4'd3);
        mid();
        tick();
        idle_in();
        mid();
        checks++;
        if ({bank_req_o, bank_we_o} !== 2'b10 || bank_addr_o !== 10'd5) begin
            failures++;
            $display("FAIL single_issue got req=%b we=%b addr=%0d exp 1 0 5",
                     bank_req_o, bank_we_o, bank_addr_o);
        end
        tick();
        mid();
        checks++;
        if ({bank_req_o, rsp_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL single_early got req=%b vld=%b exp 0 0", bank_req_o, rsp_valid_o);
        end
        tick();
        mid();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hCAFE || rsp_id_o !== 4'd3 || rsp_err_o !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp got v=%b d=%h id=%0d e=%b exp 1 cafe 3 0",
                     rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o);
        end
        tick();
        mid();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_pop got v=%b exp 0", rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] rdy;
        drv(1'b1, 10'd7, 32'h1234, 4'd0);
        mid();
        rdy[0] = req_ready_o;
        tick();
        drv(1'b0, 10'd7, '0, 4'd5);
        mid();
        rdy[1] = req_ready_o;
        checks++;
        if ({bank_req_o, bank_we_o} !== 2'b11 || bank_addr_o !== 10'd7) begin
            failures++;
            $display("FAIL b2b_wr got req=%b we=%b addr=%0d exp 1 1 7",
                     bank_req_o, bank_we_o, bank_addr_o);
        end
        tick();
        idle_in();
        mid();
        rdy[2] = req_ready_o;
        checks++;
        if ({bank_req_o, bank_we_o} !== 2'b10 || bank_addr_o !== 10'd7) begin
            failures++;
            $display("FAIL b2b_rd got req=%b we=%b addr=%0d exp 1 0 7",
                     bank_req_o, bank_we_o, bank_addr_o);
        end
        checks++;
        if (rdy !== 3'b111) begin
            failures++;
            $display("FAIL b2b_ready got %b exp 111", rdy);
        end
        tick();
        tick();
        mid();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h1234 || rsp_id_o !== 4'd5) begin
            failures++;
            $display("FAIL b2b_rsp got v=%b d=%h id=%0d exp 1 1234 5",
                     rsp_valid_o, rsp_data_o, rsp_id_o);
        end
        tick();
    endtask

    task automatic test_stall();
        int n;
        bank_ready_i = 1'b0;
        drv(1'b0, 10'd20, '0, 4'd1);
        tick();
        drv(1'b0, 10'd21, '0, 4'd2);
        mid();
        checks++;
        if (bank_req_o !== 1'b1 || bank_addr_o !== 10'd20 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_c1 got req=%b addr=%0d rdy=%b exp 1 20 1",
                     bank_req_o, bank_addr_o, req_ready_o);
        end
        tick();
        drv(1'b0, 10'd22, '0, 4'd3);
        for (int c = 0; c < 2; c++) begin
            mid();
            checks++;
            if (bank_req_o !== 1'b1 || bank_addr_o !== 10'd20 || req_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got req=%b addr=%0d rdy=%b exp 1 20 0",
                         bank_req_o, bank_addr_o, req_ready_o);
            end
            tick();
        end
        bank_ready_i = 1'b1;
        mid();
        checks++;
        if (bank_req_o !== 1'b1 || bank_addr_o !== 10'd20 || req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume got req=%b addr=%0d rdy=%b exp 1 20 0",
                     bank_req_o, bank_addr_o, req_ready_o);
        end
        tick();
        mid();
        checks++;
        if (req_ready_o !== 1'b1 || bank_addr_o !== 10'd21) begin
            failures++;
            $display("FAIL stall_next got rdy=%b addr=%0d exp 1 21", req_ready_o, bank_addr_o);
        end
        tick();
        idle_in();
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            mid();
            if (rsp_valid_o) begin
                checks++;
                if (rsp_id_o !== IW'(n + 1)) begin
                    failures++;
                    $display("FAIL stall_order got id=%0d exp %0d", rsp_id_o, n + 1);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL stall_count got %0d exp 3", n);
        end
    endtask

    task automatic test_spm_filter();
        spm_size_i = 10'd16;
        drv(1'b0, 10'd4, '0, 4'd9);
        tick();
        idle_in();
        mid();
        checks++;
        if (bank_req_o !== 1'b0) begin
            failures++;
            $display("FAIL spm_rd_req got %b exp 0", bank_req_o);
        end
        tick();
        tick();
        mid();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== '0 || rsp_id_o !== 4'd9 || rsp_err_o !== 1'b1) begin
            failures++;
            $display("FAIL spm_rd_rsp got v=%b d=%h id=%0d e=%b exp 1 0 9 1",
                     rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o);
        end
        tick();
        drv(1'b1, 10'd4, 32'hDEAD, 4'd0);
        tick();
        idle_in();
        mid();
        checks++;
        if ({illegal_wr_o, bank_req_o} !== 2'b10) begin
            failures++;
            $display("FAIL spm_wr got ill=%b req=%b exp 1 0", illegal_wr_o, bank_req_o);
        end
        tick();
        mid();
        checks++;
        if (illegal_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL spm_wr_pulse got %b exp 0", illegal_wr_o);
        end
        tick();
        drv(1'b0, 10'd16, '0, 4'd2);
        tick();
        idle_in();
        mid();
        checks++;
        if (bank_req_o !== 1'b1 || bank_addr_o !== 10'd16) begin
            failures++;
            $display("FAIL spm_edge_req got req=%b addr=%0d exp 1 16", bank_req_o, bank_addr_o);
        end
        tick();
        tick();
        mid();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_id_o !== 4'd2) begin
            failures++;
            $display("FAIL spm_edge_rsp got v=%b e=%b id=%0d exp 1 0 2",
                     rsp_valid_o, rsp_err_o, rsp_id_o);
        end
        tick();
        spm_size_i = '0;
    endtask

    task automatic test_credits();
        int grants;
        int n;
        bit acc;
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, AW'(32 + i), DW'(32'h5000 + i), 4'd0);
            tick();
        end
        idle_in();
        repeat (3) tick();
        rsp_ready_i = 1'b0;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, AW'(32 + i), '0, IW'(i));
            acc = 1'b0;
            for (int c = 0; c < 20 && !acc; c++) begin
                mid();
                acc = req_ready_o;
                if (bank_req_o && bank_ready_i) grants++;
                tick();
            end
        end
        idle_in();
        repeat (8) begin
            mid();
            if (bank_req_o && bank_ready_i) grants++;
            tick();
        end
        checks++;
        if (grants != RD) begin
            failures++;
            $display("FAIL credit_grants got %0d exp %0d", grants, RD);
        end
        rsp_ready_i = 1'b1;
        mid();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 4'd0 || rsp_data_o !== 32'h5000 || bank_req_o !== 1'b0) begin
            failures++;
            $display("FAIL credit_pop got v=%b id=%0d d=%h req=%b exp 1 0 5000 0",
                     rsp_valid_o, rsp_id_o, rsp_data_o, bank_req_o);
        end
        tick();
        rsp_ready_i = 1'b0;
        mid();
        checks++;
        if (bank_req_o !== 1'b1 || bank_addr_o !== 10'd36) begin
            failures++;
            $display("FAIL credit_reissue got req=%b addr=%0d exp 1 36", bank_req_o, bank_addr_o);
        end
        tick();
        rsp_ready_i = 1'b1;
        n = 1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            mid();
            if (rsp_valid_o) begin
                checks++;
                if (rsp_id_o !== IW'(n) || rsp_data_o !== DW'(32'h5000 + n)) begin
                    failures++;
                    $display("FAIL credit_drain got id=%0d d=%h exp %0d %h",
                             rsp_id_o, rsp_data_o, n, 32'h5000 + n);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL credit_count got %0d exp 6", n);
        end
    endtask

    task automatic test_mid_reset();
        int grants;
        int n;
        int stale;
        rsp_ready_i = 1'b0;
        drv(1'b0, 10'd40, '0, 4'd1);
        tick();
        drv(1'b0, 10'd41, '0, 4'd2);
        tick();
        idle_in();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mid();
        checks++;
        if ({req_ready_o, bank_req_o, rsp_valid_o, rsp_err_o, illegal_wr_o} !== 5'b10000) begin
            failures++;
            $display("FAIL mreset_ctrl got %b exp 10000",
                     {req_ready_o, bank_req_o, rsp_valid_o, rsp_err_o, illegal_wr_o});
        end
        stale = 0;
        tick();
        repeat (3) begin
            mid();
            if (rsp_valid_o) stale++;
            tick();
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL mreset_stale got %0d exp 0", stale);
        end
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, AW'(50 + i), '0, IW'(i));
            mid();
            if (bank_req_o && bank_ready_i) grants++;
            tick();
        end
        idle_in();
        repeat (3) begin
            mid();
            if (bank_req_o && bank_ready_i) grants++;
            tick();
        end
        checks++;
        if (grants != 4) begin
            failures++;
            $display("FAIL mreset_credit got %0d exp 4", grants);
        end
        rsp_ready_i = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            mid();
            if (rsp_valid_o) begin
                checks++;
                if (rsp_id_o !== IW'(n)) begin
                    failures++;
                    $display("FAIL mreset_order got id=%0d exp %0d", rsp_id_o, n);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL mreset_count got %0d exp 4", n);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] mm [128];
        rsp_t          exp_q [$];
        rsp_t          r;
        int            ill_exp;
        int            ill_seen;
        bit            p_stall;
        logic [AW-1:0] p_addr;
        logic          p_we;
        logic [DW-1:0] p_wd;
        for (int i = 0; i < 128; i++) mm[i] = '0;
        ill_exp  = 0;
        ill_seen = 0;
        p_stall  = 1'b0;
        p_addr   = '0;
        p_we     = 1'b0;
        p_wd     = '0;
        spm_size_i = 10'd16;
        for (int c = 0; c < 600; c++) begin
            if (c < 520) begin
                req_valid_i = ($urandom_range(0, 9) < 7);
                req_we_i    = $urandom_range(0, 1) == 1;
                req_addr_i  = $urandom_range(0, 1) == 1 ? AW'($urandom_range(0, 15))
                                                        : AW'($urandom_range(100, 115));
                req_wdata_i = $urandom;
                req_be_i    = BW'($urandom_range(1, 15));
                req_id_i    = IW'($urandom_range(0, 15));
                bank_ready_i = ($urandom_range(0, 3) != 0);
                rsp_ready_i  = ($urandom_range(0, 9) < 7);
            end else begin
                idle_in();
                bank_ready_i = 1'b1;
                rsp_ready_i  = 1'b1;
            end
            mid();
            if (req_valid_i && req_ready_o) begin
                if (req_addr_i < 16) begin
                    if (req_we_i) ill_exp++;
                    else exp_q.push_back('{d: '0, id: req_id_i, e: 1'b1});
                end else if (req_we_i) begin
                    for (int b = 0; b < BW; b++)
                        if (req_be_i[b]) mm[req_addr_i[6:0]][b*8+:8] = req_wdata_i[b*8+:8];
                end else begin
                    exp_q.push_back('{d: mm[req_addr_i[6:0]], id: req_id_i, e: 1'b0});
                end
            end
            if (illegal_wr_o) ill_seen++;
            if (bank_req_o && bank_addr_o < spm_size_i) begin
                checks++;
                failures++;
                $display("FAIL rnd_spm_leak addr=%0d below spm 16", bank_addr_o);
            end
            if (p_stall) begin
                checks++;
                if (bank_req_o !== 1'b1 || bank_addr_o !== p_addr || bank_we_o !== p_we || bank_wdata_o !== p_wd) begin
                    failures++;
                    $display("FAIL rnd_hold got req=%b addr=%0d exp 1 %0d", bank_req_o, bank_addr_o, p_addr);
                end
            end
            p_stall = bank_req_o && !bank_ready_i;
            p_addr  = bank_addr_o;
            p_we    = bank_we_o;
            p_wd    = bank_wdata_o;
            if (rsp_valid_o && rsp_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got id=%0d exp none", rsp_id_o);
                end else begin
                    r = exp_q.pop_front();
                    if (rsp_data_o !== r.d || rsp_id_o !== r.id || rsp_err_o !== r.e) begin
                        failures++;
                        $display("FAIL rnd_rsp got d=%h id=%0d e=%b exp %h %0d %b",
                                 rsp_data_o, rsp_id_o, rsp_err_o, r.d, r.id, r.e);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_missing got %0d pending exp 0", exp_q.size());
        end
        checks++;
        if (ill_seen != ill_exp) begin
            failures++;
            $display("FAIL rnd_illegal got %0d exp %0d", ill_seen, ill_exp);
        end
        spm_size_i = '0;
    endtask

    initial begin
        rst_i        = 1'b1;
        spm_size_i   = '0;
        bank_ready_i = 1'b1;
        rsp_ready_i  = 1'b1;
        idle_in();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_spm_filter();
        test_credits();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
